// File: rtl/switch_fifo_tx_path_if.sv
// Byte-path bundle between the external switch/cable port, the UART transmitter and the buffer status.
// The environment drives the master side and switch_fifo_tx_path uses the slave side.
interface switch_fifo_tx_path_if #(
    parameter int CNT_W = 10
);
    logic [7:0]       t;
    logic             tsent;
    logic             trecieve;
    logic [7:0]       out_data;
    logic             out_start;
    logic             out_finish;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_empty;
    logic             fifo_full;
    logic [7:0]       crc;
    logic [3:0]       drop_count;

    modport master (
        output t, tsent, out_finish,
        input  trecieve, out_data, out_start, fifo_count, fifo_empty, fifo_full, crc, drop_count
    );

    modport slave (
        input  t, tsent, out_finish,
        output trecieve, out_data, out_start, fifo_count, fifo_empty, fifo_full, crc, drop_count
    );
endinterface

// File: rtl/switch_fifo_tx_path.sv
// Captures handshaked bytes into a circular FIFO and hands them one at a time to the UART transmitter.
// Define CRC8_EN to compute a running CRC-8 (poly 0x07) over accepted bytes; otherwise crc reads 0x00.
module switch_fifo_tx_path #(
    parameter int DEPTH = 512,
    parameter int CNT_W = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    switch_fifo_tx_path_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {IN_IDLE, IN_WRITE, IN_ACK} inState_t;
    typedef enum logic [1:0] {OUT_IDLE, OUT_START, OUT_WAIT} outState_t;

    logic             r_tsentMeta, r_tsentS, r_tsentD;
    inState_t         r_inState;
    outState_t        r_outState;
    logic [7:0]       r_holdByte;
    logic             r_trecieve;
    logic [3:0]       r_dropCount;
    logic [7:0]       r_mem [DEPTH];
    logic [PTR_W-1:0] r_wrPtr, r_rdPtr;
    logic [CNT_W-1:0] r_count;
    logic [7:0]       r_outData;
    logic             r_outStart;
    logic             w_full, w_empty, w_push, w_pop;
    logic [7:0]       w_head;
    logic [7:0]       w_crc;

    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_push  = (r_inState == IN_WRITE) && !w_full;
    assign w_pop   = (r_outState == OUT_IDLE) && !w_empty;
    assign w_head  = r_mem[r_rdPtr];

    // Synchronizer and history flops come out of reset high so a strobe held through reset is not a new byte.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tsentMeta <= 1'b1;
            r_tsentS    <= 1'b1;
            r_tsentD    <= 1'b1;
        end else begin
            r_tsentMeta <= bus.tsent;
            r_tsentS    <= r_tsentMeta;
            r_tsentD    <= r_tsentS;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_inState   <= IN_IDLE;
            r_holdByte  <= 8'h00;
            r_trecieve  <= 1'b0;
            r_dropCount <= 4'd0;
        end else begin
            case (r_inState)
                IN_IDLE: begin
                    if (r_tsentS && !r_tsentD) begin
                        r_holdByte <= bus.t;
                        r_inState  <= IN_WRITE;
                    end
                end
                IN_WRITE: begin
                    if (w_full && (r_dropCount != 4'd15)) begin
                        r_dropCount <= r_dropCount + 4'd1;
                    end
                    r_trecieve <= 1'b1;
                    r_inState  <= IN_ACK;
                end
                IN_ACK: begin
                    if (!r_tsentS) begin
                        r_trecieve <= 1'b0;
                        r_inState  <= IN_IDLE;
                    end
                end
                default: begin
                    r_trecieve <= 1'b0;
                    r_inState  <= IN_IDLE;
                end
            endcase
        end
    end

    // Storage array carries no reset; the pointers and count alone define what is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= r_holdByte;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_outState <= OUT_IDLE;
            r_outData  <= 8'h00;
            r_outStart <= 1'b0;
        end else begin
            case (r_outState)
                OUT_IDLE: begin
                    if (!w_empty) begin
                        r_outData  <= w_head;
                        r_outStart <= 1'b1;
                        r_outState <= OUT_START;
                    end
                end
                OUT_START: begin
                    r_outStart <= 1'b0;
                    r_outState <= OUT_WAIT;
                end
                OUT_WAIT: begin
                    if (bus.out_finish) begin
                        r_outState <= OUT_IDLE;
                    end
                end
                default: begin
                    r_outStart <= 1'b0;
                    r_outState <= OUT_IDLE;
                end
            endcase
        end
    end

`ifdef CRC8_EN
    logic [7:0] r_crc;

    function automatic logic [7:0] crc8Next(input logic [7:0] crcIn, input logic [7:0] data);
        logic [7:0] c;
        c = crcIn ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        end
        return c;
    endfunction

    // Only bytes that actually enter the FIFO contribute; dropped bytes leave the CRC untouched.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_crc <= 8'h00;
        end else if (w_push) begin
            r_crc <= crc8Next(r_crc, r_holdByte);
        end
    end

    assign w_crc = r_crc;
`else
    assign w_crc = 8'h00;
`endif

    assign bus.trecieve   = r_trecieve;
    assign bus.out_data   = r_outData;
    assign bus.out_start  = r_outStart;
    assign bus.fifo_count = r_count;
    assign bus.fifo_empty = w_empty;
    assign bus.fifo_full  = w_full;
    assign bus.crc        = w_crc;
    assign bus.drop_count = r_dropCount;
endmodule

// File: tb/tb_switch_fifo_tx_path.sv
// Randomized self-checking bench for switch_fifo_tx_path against a queue-based reference model.
// Expected crc follows the CRC8_EN build option (0x00 when the macro is undefined).
module tb_switch_fifo_tx_path;
    localparam int DEPTH = 512;
    localparam int CNT_W = 10;

    logic clk = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    switch_fifo_tx_path_if #(.CNT_W(CNT_W)) bus ();

    switch_fifo_tx_path #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checkCount = 0;
    int passCount  = 0;

    logic [7:0] expQ[$];
    logic [7:0] obsQ[$];
    logic [7:0] modelCrc = 8'h00;
    int         modelDrops = 0;
    int         startCount = 0;
    int         pulseErr = 0;
    bit         prevStart = 1'b0;

    // Every out_start pulse hands one byte to the transmitter; record it and flag pulses longer than a cycle.
    always @(negedge clk) begin
        if (bus.out_start === 1'b1) begin
            obsQ.push_back(bus.out_data);
            startCount++;
            if (prevStart) pulseErr++;
        end
        prevStart = (bus.out_start === 1'b1);
    end

    // Bit-serial CRC-8, poly x^8+x^2+x+1, message bits fed MSB first.
    function automatic logic [7:0] refCrc(input logic [7:0] c0, input logic [7:0] d);
        logic [7:0] c;
        logic fb;
        c = c0;
        for (int b = 7; b >= 0; b--) begin
            fb = c[7] ^ d[b];
            c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
        end
        return c;
    endfunction

    function automatic logic [7:0] expectedCrc();
`ifdef CRC8_EN
        return modelCrc;
`else
        return 8'h00;
`endif
    endfunction

    function automatic logic [7:0] crcIfEnabled(input logic [7:0] v);
`ifdef CRC8_EN
        return v;
`else
        return 8'h00;
`endif
    endfunction

    task automatic clearModel();
        expQ.delete();
        obsQ.delete();
        modelCrc   = 8'h00;
        modelDrops = 0;
    endtask

    task automatic modelAccept(input logic [7:0] d);
        if ((expQ.size() - obsQ.size()) < DEPTH) begin
            expQ.push_back(d);
            modelCrc = refCrc(modelCrc, d);
        end else if (modelDrops < 15) begin
            modelDrops++;
        end
    endtask

    task automatic sendByte(input logic [7:0] d);
        int n;
        @(negedge clk);
        bus.t = d;
        bus.tsent = 1'b1;
        modelAccept(d);
        n = 0;
        while (bus.trecieve !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkCount++;
        if (n < 3 || n > 6) $display("[TB] FAIL ack_rise byte=%02h cycles=%0d required 3..6", d, n);
        else passCount++;
        bus.tsent = 1'b0;
        n = 0;
        while (bus.trecieve !== 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkCount++;
        if (n < 2 || n > 4) $display("[TB] FAIL ack_fall byte=%02h cycles=%0d required 2..4", d, n);
        else passCount++;
    endtask

    task automatic pulseFinish();
        @(negedge clk);
        bus.out_finish = 1'b1;
        @(negedge clk);
        bus.out_finish = 1'b0;
    endtask

    task automatic drainAndCompare(input string tag);
        int n;
        int mism;
        bus.out_finish = 1'b1;
        n = 0;
        while (obsQ.size() < expQ.size() && n < 4000) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        bus.out_finish = 1'b0;
        repeat (2) @(negedge clk);
        checkCount++;
        if (obsQ.size() != expQ.size()) $display("[TB] FAIL %s_count got=%0d required=%0d", tag, obsQ.size(), expQ.size());
        else passCount++;
        mism = 0;
        for (int i = 0; i < expQ.size(); i++) begin
            if (i >= obsQ.size() || obsQ[i] !== expQ[i]) mism++;
        end
        checkCount++;
        if (mism != 0) $display("[TB] FAIL %s_order mismatched=%0d required=0", tag, mism);
        else passCount++;
        checkCount++;
        if (bus.fifo_empty !== 1'b1) $display("[TB] FAIL %s_empty got=%b required=1", tag, bus.fifo_empty);
        else passCount++;
        checkCount++;
        if (bus.crc !== expectedCrc()) $display("[TB] FAIL %s_crc got=%02h required=%02h", tag, bus.crc, expectedCrc());
        else passCount++;
        checkCount++;
        if (bus.drop_count !== 4'(modelDrops)) $display("[TB] FAIL %s_drops got=%0d required=%0d", tag, bus.drop_count, modelDrops);
        else passCount++;
    endtask

    task automatic test_reset();
        bus.t = 8'hA5;
        bus.tsent = 1'b1;
        bus.out_finish = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        clearModel();
        repeat (10) @(negedge clk);
        checkCount++;
        if (bus.trecieve !== 1'b0) $display("[TB] FAIL rst_trecieve got=%b required=0", bus.trecieve);
        else passCount++;
        checkCount++;
        if (bus.fifo_empty !== 1'b1 || bus.fifo_count !== '0) $display("[TB] FAIL rst_fifo got empty=%b count=%0d required 1/0", bus.fifo_empty, bus.fifo_count);
        else passCount++;
        checkCount++;
        if (bus.fifo_full !== 1'b0 || bus.out_start !== 1'b0 || bus.out_data !== 8'h00) $display("[TB] FAIL rst_out got full=%b start=%b data=%02h required 0/0/00", bus.fifo_full, bus.out_start, bus.out_data);
        else passCount++;
        checkCount++;
        if (bus.crc !== 8'h00 || bus.drop_count !== 4'd0) $display("[TB] FAIL rst_crc_drop got crc=%02h drops=%0d required 00/0", bus.crc, bus.drop_count);
        else passCount++;
        bus.tsent = 1'b0;
        repeat (6) @(negedge clk);
        checkCount++;
        if (bus.fifo_empty !== 1'b1 || startCount != 0) $display("[TB] FAIL rst_held_strobe got empty=%b starts=%0d required 1/0", bus.fifo_empty, startCount);
        else passCount++;
    endtask

    task automatic test_two_bytes();
        sendByte(8'h01);
        repeat (3) @(negedge clk);
        checkCount++;
        if (obsQ.size() != 1 || obsQ[0] !== 8'h01) $display("[TB] FAIL first_out got n=%0d required one byte 01", obsQ.size());
        else passCount++;
        checkCount++;
        if (bus.crc !== crcIfEnabled(8'h07)) $display("[TB] FAIL crc_first got=%02h required=%02h", bus.crc, crcIfEnabled(8'h07));
        else passCount++;
        sendByte(8'h02);
        repeat (3) @(negedge clk);
        checkCount++;
        if (bus.crc !== crcIfEnabled(8'h1B)) $display("[TB] FAIL crc_second got=%02h required=%02h", bus.crc, crcIfEnabled(8'h1B));
        else passCount++;
        checkCount++;
        if (bus.fifo_count !== CNT_W'(1) || obsQ.size() != 1) $display("[TB] FAIL hold_second got count=%0d starts=%0d required 1/1", bus.fifo_count, obsQ.size());
        else passCount++;
        pulseFinish();
        repeat (4) @(negedge clk);
        checkCount++;
        if (obsQ.size() != 2 || obsQ[1] !== 8'h02) $display("[TB] FAIL second_out got n=%0d required two bytes ending 02", obsQ.size());
        else passCount++;
        pulseFinish();
        repeat (10) @(negedge clk);
        checkCount++;
        if (obsQ.size() != 2 || bus.fifo_empty !== 1'b1) $display("[TB] FAIL idle_after got n=%0d empty=%b required 2/1", obsQ.size(), bus.fifo_empty);
        else passCount++;
    endtask

    task automatic test_fill_and_drop();
        for (int i = 0; i <= DEPTH; i++) sendByte(8'($urandom));
        repeat (3) @(negedge clk);
        checkCount++;
        if (bus.fifo_full !== 1'b1 || bus.fifo_count !== CNT_W'(DEPTH)) $display("[TB] FAIL fill got full=%b count=%0d required 1/%0d", bus.fifo_full, bus.fifo_count, DEPTH);
        else passCount++;
        for (int i = 0; i < 2; i++) sendByte(8'($urandom));
        checkCount++;
        if (bus.drop_count !== 4'd2 || bus.fifo_count !== CNT_W'(DEPTH)) $display("[TB] FAIL drop_two got drops=%0d count=%0d required 2/%0d", bus.drop_count, bus.fifo_count, DEPTH);
        else passCount++;
        for (int i = 0; i < 15; i++) sendByte(8'($urandom));
        checkCount++;
        if (bus.drop_count !== 4'd15) $display("[TB] FAIL drop_saturate got=%0d required=15", bus.drop_count);
        else passCount++;
        drainAndCompare("fill_drain");
    endtask

    task automatic test_push_pop_same_cycle();
        logic [7:0] d;
        int n;
        int minC;
        int maxC;
        for (int i = 0; i < 6; i++) sendByte(8'($urandom));
        repeat (3) @(negedge clk);
        checkCount++;
        if (bus.fifo_count !== CNT_W'(5)) $display("[TB] FAIL pp_setup got=%0d required=5", bus.fifo_count);
        else passCount++;
        // Strobe rises now; the write lands on the 4th rising edge, the pop is timed to the same edge.
        @(negedge clk);
        d = 8'($urandom);
        bus.t = d;
        bus.tsent = 1'b1;
        modelAccept(d);
        repeat (2) @(negedge clk);
        bus.out_finish = 1'b1;
        @(negedge clk);
        bus.out_finish = 1'b0;
        minC = 1000;
        maxC = -1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (int'(bus.fifo_count) < minC) minC = int'(bus.fifo_count);
            if (int'(bus.fifo_count) > maxC) maxC = int'(bus.fifo_count);
        end
        checkCount++;
        if (minC != 5 || maxC != 5) $display("[TB] FAIL pp_count got min=%0d max=%0d required 5/5", minC, maxC);
        else passCount++;
        checkCount++;
        if (bus.trecieve !== 1'b1) $display("[TB] FAIL pp_ack got=%b required=1", bus.trecieve);
        else passCount++;
        bus.tsent = 1'b0;
        n = 0;
        while (bus.trecieve !== 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkCount++;
        if (n >= 20) $display("[TB] FAIL pp_ack_fall got timeout required release");
        else passCount++;
        drainAndCompare("pp_drain");
    endtask

    task automatic test_random();
        bit done;
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 40; i++) sendByte(8'($urandom));
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(negedge clk);
                    bus.out_finish = 1'($urandom_range(0, 1));
                end
            end
        join
        drainAndCompare("rand_drain");
        checkCount++;
        if (pulseErr != 0) $display("[TB] FAIL start_width got long pulses=%0d required=0", pulseErr);
        else passCount++;
    endtask

    task automatic test_reset_mid();
        int sc;
        bus.out_finish = 1'b0;
        for (int i = 0; i < 4; i++) sendByte(8'($urandom));
        repeat (3) @(negedge clk);
        checkCount++;
        if (bus.fifo_count !== CNT_W'(3)) $display("[TB] FAIL mid_setup got=%0d required=3", bus.fifo_count);
        else passCount++;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        clearModel();
        @(negedge clk);
        checkCount++;
        if (bus.trecieve !== 1'b0 || bus.out_start !== 1'b0 || bus.out_data !== 8'h00) $display("[TB] FAIL mid_out got ack=%b start=%b data=%02h required 0/0/00", bus.trecieve, bus.out_start, bus.out_data);
        else passCount++;
        checkCount++;
        if (bus.fifo_count !== '0 || bus.fifo_empty !== 1'b1 || bus.fifo_full !== 1'b0) $display("[TB] FAIL mid_fifo got count=%0d empty=%b full=%b required 0/1/0", bus.fifo_count, bus.fifo_empty, bus.fifo_full);
        else passCount++;
        checkCount++;
        if (bus.crc !== 8'h00 || bus.drop_count !== 4'd0) $display("[TB] FAIL mid_crc_drop got crc=%02h drops=%0d required 00/0", bus.crc, bus.drop_count);
        else passCount++;
        sc = startCount;
        pulseFinish();
        repeat (10) @(negedge clk);
        checkCount++;
        if (startCount != sc) $display("[TB] FAIL mid_no_start got=%0d extra starts required=0", startCount - sc);
        else passCount++;
        sendByte(8'h5A);
        repeat (3) @(negedge clk);
        checkCount++;
        if (obsQ.size() != 1 || obsQ[0] !== 8'h5A) $display("[TB] FAIL mid_resume got n=%0d required one byte 5a", obsQ.size());
        else passCount++;
        checkCount++;
        if (bus.crc !== expectedCrc()) $display("[TB] FAIL mid_resume_crc got=%02h required=%02h", bus.crc, expectedCrc());
        else passCount++;
    endtask

    initial begin
        bus.t = 8'h00;
        bus.tsent = 1'b0;
        bus.out_finish = 1'b0;
        test_reset();
        test_two_bytes();
        test_fill_and_drop();
        test_push_pop_same_cycle();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

    initial begin
        #5000000;
        $display("[TB] FAIL watchdog got timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
